// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 Hz raster constants and position type for the VGA display path.
package vga_timing_pkg;

  localparam int unsigned POS_W = 10;
  typedef logic [POS_W-1:0] pos_t;

  localparam int unsigned VGA_H_VISIBLE = 640;
  localparam int unsigned VGA_H_FRONT   = 16;
  localparam int unsigned VGA_H_SYNC    = 96;
  localparam int unsigned VGA_H_BACK    = 48;
  localparam int unsigned VGA_V_VISIBLE = 480;
  localparam int unsigned VGA_V_FRONT   = 10;
  localparam int unsigned VGA_V_SYNC    = 2;
  localparam int unsigned VGA_V_BACK    = 33;

  localparam int unsigned VGA_H_TOTAL      = VGA_H_VISIBLE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
  localparam int unsigned VGA_V_TOTAL      = VGA_V_VISIBLE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;
  localparam int unsigned VGA_H_SYNC_START = VGA_H_VISIBLE + VGA_H_FRONT;
  localparam int unsigned VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC - 1;
  localparam int unsigned VGA_V_SYNC_START = VGA_V_VISIBLE + VGA_V_FRONT;
  localparam int unsigned VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC - 1;

  function automatic logic in_window(input pos_t p, input pos_t lo, input pos_t hi);
    return (p >= lo) && (p <= hi);
  endfunction

endpackage

// File: rtl/pixel_clk_div.sv
// Pixel-rate divider: pixelTick is a registered decode that is high exactly while
// divCnt==CLK_DIV-1, i.e. on the clocks where the raster counters must advance.
module pixel_clk_div #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic pixelTick
);

  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t LAST     = cnt_t'(CLK_DIV - 1);
  // Reset value matches the decode of divCnt==0 so CLK_DIV=1 advances on the first edge.
  localparam logic TICK_RST = (CLK_DIV == 1) ? 1'b1 : 1'b0;

  cnt_t div_q, div_d;
  logic tick_q, tick_d;

  // Next divider count and look-ahead decode of the advance clock
  always_comb begin
    div_d  = div_q;
    tick_d = 1'b0;
    if (div_q == LAST) begin
      div_d = '0;
    end else begin
      div_d = div_q + cnt_t'(1);
    end
    tick_d = (div_d == LAST);
  end

  // Divider state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q  <= '0;
      tick_q <= TICK_RST;
    end else begin
      div_q  <= div_d;
      tick_q <= tick_d;
    end
  end

  assign pixelTick = tick_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: position counters plus registered sync/visible/frame-start
// decode taken from the next-state positions so status lines up with hPos/vPos.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 2,
  parameter int unsigned H_VISIBLE = VGA_H_VISIBLE,
  parameter int unsigned H_FRONT   = VGA_H_FRONT,
  parameter int unsigned H_SYNC    = VGA_H_SYNC,
  parameter int unsigned H_BACK    = VGA_H_BACK,
  parameter int unsigned V_VISIBLE = VGA_V_VISIBLE,
  parameter int unsigned V_FRONT   = VGA_V_FRONT,
  parameter int unsigned V_SYNC    = VGA_V_SYNC,
  parameter int unsigned V_BACK    = VGA_V_BACK
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             pixelTick,
  output logic [POS_W-1:0] hPos,
  output logic [POS_W-1:0] vPos,
  output logic             hSync,
  output logic             vSync,
  output logic             videoOn,
  output logic             frameStart
);

  localparam pos_t H_LAST = pos_t'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam pos_t V_LAST = pos_t'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam pos_t H_VIS  = pos_t'(H_VISIBLE);
  localparam pos_t V_VIS  = pos_t'(V_VISIBLE);
  localparam pos_t H_SS   = pos_t'(H_VISIBLE + H_FRONT);
  localparam pos_t H_SE   = pos_t'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam pos_t V_SS   = pos_t'(V_VISIBLE + V_FRONT);
  localparam pos_t V_SE   = pos_t'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  logic adv;
  pos_t hpos_q, hpos_d, vpos_q, vpos_d;
  logic tick_q, hsync_q, hsync_d, vsync_q, vsync_d;
  logic von_q, von_d, fs_q, fs_d;

  pixel_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .pixelTick (adv)
  );

  // Next raster position: hPos wraps each line, vPos steps only on the hPos wrap
  always_comb begin
    hpos_d = hpos_q;
    vpos_d = vpos_q;
    if (adv) begin
      if (hpos_q == H_LAST) begin
        hpos_d = '0;
        if (vpos_q == V_LAST) begin
          vpos_d = '0;
        end else begin
          vpos_d = vpos_q + pos_t'(1);
        end
      end else begin
        hpos_d = hpos_q + pos_t'(1);
      end
    end else begin
      hpos_d = hpos_q;
    end
  end

  // Status decode from the next position
  always_comb begin
    hsync_d = ~in_window(hpos_d, H_SS, H_SE);
    vsync_d = ~in_window(vpos_d, V_SS, V_SE);
    von_d   = (hpos_d < H_VIS) && (vpos_d < V_VIS);
    fs_d    = adv && (hpos_d == '0) && (vpos_d == '0);
  end

  // Position and status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hpos_q  <= H_LAST;
      vpos_q  <= V_LAST;
      tick_q  <= 1'b0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      von_q   <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      hpos_q  <= hpos_d;
      vpos_q  <= vpos_d;
      tick_q  <= adv;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      von_q   <= von_d;
      fs_q    <= fs_d;
    end
  end

  assign pixelTick  = tick_q;
  assign hPos       = hpos_q;
  assign vPos       = vpos_q;
  assign hSync      = hsync_q;
  assign vSync      = vsync_q;
  assign videoOn    = von_q;
  assign frameStart = fs_q;

endmodule
